// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 signed/unsigned multiply, divide, multiply-add and multiply-subtract engine producing {HI,LO}
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [W-1:0] m, abs_a, abs_b, new_rem, quo, rem;
  logic [2*W-1:0] p, hilo_q, step, prod, fix;
  logic [CW-1:0] cnt;
  logic neg_a, neg_b, dbz_q;
  logic is_div_in, sgn_in, dz, accept, last, is_div, sgn, ge;
  logic [W:0] mul_sum, shifted;
  always_comb begin
    is_div_in = op_i[2:1] == 2'b01;
    sgn_in = !op_i[0];
    abs_a = (sgn_in && a_i[W-1]) ? -a_i : a_i;
    abs_b = (sgn_in && b_i[W-1]) ? -b_i : b_i;
    dz = is_div_in && (b_i == '0);
    accept = (state == IDLE || state == DONE) && start_i && !annul_i;
    last = cnt == CW'(W - 1);
    is_div = op_q[2:1] == 2'b01;
    sgn = !op_q[0];
    mul_sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
    shifted = p[2*W-1:W-1];
    ge = shifted >= {1'b0, m};
    new_rem = ge ? W'(shifted - {1'b0, m}) : W'(shifted);
    step = is_div ? {new_rem, p[W-2:0], ge} : {mul_sum, p[W-1:1]};
    prod = (sgn && (neg_a ^ neg_b)) ? -p : p;
    quo = (sgn && (neg_a ^ neg_b)) ? -p[W-1:0] : p[W-1:0];
    rem = (sgn && neg_a) ? -p[2*W-1:W] : p[2*W-1:W];
    fix = is_div ? {rem, quo} : !op_q[2] ? prod : op_q[1] ? hilo_q - prod : hilo_q + prod;
    state_n = annul_i ? IDLE :
              accept ? (dz ? DONE : CALC) :
              state == CALC ? (last ? FIXUP : CALC) :
              state == FIXUP ? DONE :
              state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      m <= '0;
      p <= '0;
      hilo_q <= '0;
      cnt <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dbz_q <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= op_i;
        m <= is_div_in ? abs_b : abs_a;
        p <= {{W{1'b0}}, is_div_in ? abs_a : abs_b};
        hilo_q <= hilo_i;
        cnt <= '0;
        neg_a <= sgn_in && a_i[W-1];
        neg_b <= sgn_in && b_i[W-1];
        dbz_q <= dz;
        if (dz) result_o <= {a_i, {W{1'b1}}};
      end else if (state == CALC) begin
        p <= step;
        cnt <= cnt + CW'(1);
      end
      if (state == FIXUP && !annul_i) result_o <= fix;
    end
  end
  assign busy_o = state == CALC || state == FIXUP;
  assign ready_o = state == DONE && !annul_i;
  assign div_by_zero_o = ready_o && dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 0, rst = 1, start = 0, annul = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] hilo = 0, result, saved;
  logic busy, ready, dbz;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hilo_i(hilo), .annul_i(annul), .busy_o(busy), .ready_o(ready),
    .result_o(result), .div_by_zero_o(dbz)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] h);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] ux, uy, pr, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o[2:1] == 2'b01) begin
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (o[0]) begin
        q = ux / uy;
        r = ux % uy;
      end else begin
        sq = sx / sy;
        sr = sx % sy;
        q = sq;
        r = sr;
      end
      return {r[31:0], q[31:0]};
    end
    if (o[0]) pr = ux * uy;
    else begin
      sp = sx * sy;
      pr = sp;
    end
    if (!o[2]) return pr;
    return o[1] ? h - pr : h + pr;
  endfunction
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] h);
    op = o;
    a = x;
    b = y;
    hilo = h;
    start = 1;
  endtask
  task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] h);
    int n, bc;
    logic z;
    z = o[2:1] == 2'b01 && y == 0;
    n = 1;
    bc = 0;
    while (!ready && n < 100) begin
      bc += busy;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), z ? 64'd1 : 64'd34);
    chk({tag, "_busy"}, 64'(bc), z ? 64'd0 : 64'd33);
    chk({tag, "_res"}, result, model(o, x, y, h));
    chk({tag, "_dbz"}, 64'(dbz), 64'(z));
  endtask
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] h);
    @(negedge clk);
    issue(o, x, y, h);
    @(negedge clk);
    start = 0;
    a = $urandom;
    b = $urandom;
    hilo = {$urandom, $urandom};
    wait_done(tag, o, x, y, h);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(ready), 64'd0);
  endtask
  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic [63:0] rh;
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(ready), 0);
    chk("rst_dbz", 64'(dbz), 0);
    chk("rst_res", result, 0);
    rst = 0;
    do_op("div_neg7", 3'b010, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg7_val", result, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_val", result, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("msub", 3'b110, 32'd3, 32'hFFFF_FFFE, 64'h10);
    chk("msub_val", result, 64'h16);
    do_op("maddu_wrap", 3'b101, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("divu_zero", 3'b011, 32'h1234, 32'd0, 0);
    chk("divu_zero_val", result, 64'h0000_1234_FFFF_FFFF);
    do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_val", result, 64'h0000_0000_8000_0000);
    do_op("div_zero_s", 3'b010, 32'h8000_0000, 32'd0, 0);
    saved = result;
    @(negedge clk);
    issue(3'b010, 32'd1000, 32'd7, 0);
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    annul = 1;
    @(negedge clk);
    annul = 0;
    chk("annul_busy", 64'(busy), 0);
    chk("annul_ready", 64'(ready), 0);
    chk("annul_res", result, saved);
    do_op("after_annul", 3'b011, 32'd1000, 32'd7, 0);
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd6, 0);
    annul = 1;
    @(negedge clk);
    start = 0;
    annul = 0;
    chk("annul_prio_busy", 64'(busy), 0);
    @(negedge clk);
    issue(3'b001, 32'd12345, 32'd678, 0);
    @(negedge clk);
    start = 0;
    wait_done("b2b1", 3'b001, 32'd12345, 32'd678, 0);
    issue(3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    start = 0;
    wait_done("b2b2", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    issue(3'b000, 32'd77, 32'd99, 0);
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_ready", 64'(ready), 0);
    chk("midrst_res", result, 0);
    @(negedge clk);
    rst = 0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += ready;
    end
    chk("midrst_noready", 64'(cnt), 0);
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      rh = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), ro, ra, rb, rh);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide engine for the EX stage of the five-stage MIPS pipeline. It supersedes the fixed 32-bit divider that has a tied-off annul input. It executes signed and unsigned MULT, DIV, MADD and MSUB over WIDTH-bit operands and produces a 2·WIDTH HI/LO result. It supports flush-driven annul and a one-cycle divide-by-zero path. The hazard unit stalls E while `busy_o` is high; the HI/LO register commits `result_o` on `ready_o`.

## Interface
- WIDTH, 32, operand width; must be ≥ 2; HI/LO each WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only in IDLE or DONE.
- op_i  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- a_i  in  WIDTH  rs operand, i.e. the dividend or multiplicand.
- b_i  in  WIDTH  rt operand, i.e. the divisor or multiplier.
- hilo_i  in  2·WIDTH  current {HI,LO}, used by MADD/MSUB.
- annul_i  in  1  abort the current operation (pipeline flush).
- busy_o  out  1  operation in progress.
- ready_o  out  1  one-cycle completion pulse.
- result_o  out  2·WIDTH  {HI,LO}; for MUL-class ops it is the product or accumulated value; for DIV-class ops it is {remainder, quotient}.
- div_by_zero_o  out  1  pulses with `ready_o` when a DIV/DIVU divisor was zero.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE to CALC: on `start_i` && !`annul_i`, latch the following:
  - op;
  - magnitudes |a|, |b| (signed ops only; unsigned ops take raw values);
  - the sign flags;
  - `hilo_i`;
  - an iteration counter cleared to 0.
- DIV/DIVU with b_i == 0 skips CALC and goes straight to DONE. It loads `result_o` = {a_i, all-ones}, and `div_by_zero_o` = 1 in DONE.
- CALC performs one radix-2 step per cycle for exactly WIDTH cycles, then moves to FIXUP.
  - Multiply uses shift-add: a 2·WIDTH accumulator with the multiplier shifted right.
  - Divide uses restoring division: partial remainder WIDTH+1 bits, with a quotient bit shifted in each step.
- FIXUP takes one cycle, then moves to DONE. It applies these corrections:
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - MADD: result = hilo + product, modulo 2^(2·WIDTH).
  - MSUB: result = hilo − product, modulo 2^(2·WIDTH).
  - Register `result_o`.
- DONE lasts one cycle with `ready_o` = 1. It then returns to IDLE, or to CALC if `start_i` is high (back-to-back operations).
- Signed overflow: most-negative ÷ −1 gives quotient = most-negative (wraps) and remainder = 0. No exception is raised.
- `start_i` in CALC or FIXUP is ignored.
- `annul_i` in CALC, FIXUP or DONE sends the state to IDLE at the next edge.
  - Any `ready_o` or `div_by_zero_o` pulse for that operation is suppressed.
  - `result_o` keeps its previous value.
  - `annul_i` has priority over `start_i`.
- `result_o` holds the last completed value until the next completion.

## Timing
- Reset (asynchronous):
  - Outputs: `busy_o` = 0, `ready_o` = 0, `div_by_zero_o` = 0, `result_o` = 0.
  - Internal state: IDLE, counter 0.
- Reset mid-operation abandons the operation immediately, with no `ready_o`.
- Start accepted at edge E0:
  - `busy_o` is high from E0 through E(WIDTH+1).
  - `ready_o` is high for the cycle following edge E(WIDTH+1).
  - Latency is WIDTH+2 edges; for WIDTH=32, `ready_o` is seen 34 cycles after start.
- Divide-by-zero: `ready_o` and `div_by_zero_o` are high in the cycle after E0; `busy_o` stays 0.
- `busy_o` = 0 in DONE.
- `ready_o` and `div_by_zero_o` are never high for more than one consecutive cycle per operation.
- Operand inputs need only be valid at the accepting edge.

## Test plan
- DIV a=0xFFFFFFF9 (−7), b=2 → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. `ready_o` must pulse for exactly one cycle, 34 cycles after the start edge, with `busy_o` high for the 33 cycles before it.
- MULTU a=b=0xFFFFFFFF → `result_o` = 0xFFFFFFFE_00000001. MULT with the same operands → 0x00000000_00000001.
- MSUB hilo_i=0x10, a=3, b=0xFFFFFFFE → `result_o` = 0x16. MADDU with hilo_i=0xFFFFFFFF_FFFFFFFF, a=1, b=1 → 0 (wrap).
- DIVU a=0x1234, b=0 → `ready_o` and `div_by_zero_o` high in the cycle after start, `result_o` = {0x00001234, 0xFFFFFFFF}. DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Annul test:
  - Start a DIV, then assert `annul_i` at CALC cycle 10 → `busy_o` = 0 next cycle, no `ready_o`, `result_o` unchanged.
  - A start issued the following cycle completes normally with its own result.
- Back-to-back test:
  - Pulse `start_i` again in the DONE cycle → the second operation is accepted and its `ready_o` appears WIDTH+2 edges later.
  - Assert `rst` during CALC → all outputs become 0 immediately and no `ready_o` follows.
